stim_seq_ctrl: RTL and testbench

STIM_SEQ_CTRL -- requirements
Module: stim_seq_ctrl

---
 rtl/stim_seq_ctrl_if.sv | 10 +
 rtl/stim_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_stim_seq_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_seq_ctrl_if.sv
// Command-word handshake between the stimulation sequencer (master) and the
// DAC command sink (slave).
interface stim_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;

  modport master (output cmd_valid, output cmd_word, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_word, output cmd_ready);
endinterface

// File: rtl/stim_seq_ctrl.sv
// Biphasic stimulation train sequencer issuing DAC command words over a valid/ready link.
// Optional charge-balance compensation stage is enabled by defining STIM_SEQ_COMP_EN.
module stim_seq_ctrl #(
  parameter int unsigned CB_TIMEOUT = 65535
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [9:0]             cfg_addr,
  input  logic [8:0]             cfg_amp_neg,
  input  logic [8:0]             cfg_amp_pos,
  input  logic                   cfg_x50,
  input  logic [1:0]             cfg_ele,
  input  logic [15:0]            cfg_t_phase,
  input  logic [15:0]            cfg_t_ipg,
  input  logic [7:0]             cfg_n_pulses,
  stim_seq_ctrl_if.master        cmd,
  input  logic                   cb_ok,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic [7:0]             pulse_cnt
);

  localparam logic [5:0] CODE_STIM  = 6'd6;
  localparam logic [5:0] CODE_CBCLR = 6'd18;

  typedef enum logic [3:0] {
    S_IDLE, S_NEG, S_NEG_WAIT, S_ZERO, S_IPG_WAIT, S_POS, S_POS_WAIT, S_OFF, S_DONE
`ifdef STIM_SEQ_COMP_EN
    , S_COMP_ON, S_COMP_OFF, S_POLL_CB, S_CB_CLR
`endif
  } state_t;

  state_t      state, state_n;
  logic [9:0]  addr_q;
  logic [8:0]  amp_neg_q, amp_pos_q;
  logic        x50_q, abort_q;
  logic [1:0]  ele_q;
  logic [15:0] t_phase_q, t_ipg_q, timer;
  logic [7:0]  n_pulses_q;
  logic        vld, xfer, abort_pend, timer_last, more_pulses, pulse_inc;
  logic [5:0]  code;
  logic [15:0] data;

  function automatic logic [15:0] max1(input logic [15:0] t);
    return (t == '0) ? 16'd1 : t;
  endfunction

  assign xfer        = vld & cmd.cmd_ready;
  assign abort_pend  = abort_q | abort;
  assign timer_last  = (timer <= 16'd1);
  assign more_pulses = ({1'b0, pulse_cnt} + 9'd1) < {1'b0, n_pulses_q};
  assign pulse_inc   = (state == S_POS_WAIT) && !abort_pend && timer_last;

  assign cmd.cmd_valid = vld;
  assign cmd.cmd_word  = vld ? {code, addr_q, data} : '0;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Command states leave only on a completed handshake, so an abort seen there
  // is honoured after the word goes out; timed states bail out immediately.
  always_comb begin
    state_n = state;
    vld     = 1'b0;
    code    = CODE_STIM;
    data    = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (abort) state_n = S_OFF;
`ifdef STIM_SEQ_COMP_EN
          else state_n = S_COMP_ON;
`else
          else if (cfg_n_pulses == '0) state_n = S_OFF;
          else state_n = S_NEG;
`endif
        end
      end
`ifdef STIM_SEQ_COMP_EN
      S_COMP_ON: begin
        vld  = 1'b1;
        data = {1'b0, ele_q, x50_q, 1'b1, 2'b00, amp_neg_q};
        if (cmd.cmd_ready) state_n = abort_pend ? S_OFF : S_COMP_OFF;
      end
      S_COMP_OFF: begin
        vld  = 1'b1;
        data = {1'b0, ele_q, x50_q, 1'b0, 2'b00, amp_neg_q};
        if (cmd.cmd_ready) state_n = abort_pend ? S_OFF : S_POLL_CB;
      end
      S_POLL_CB: begin
        if (abort_pend)      state_n = S_OFF;
        else if (cb_ok)      state_n = S_CB_CLR;
        else if (timer_last) state_n = S_OFF;
      end
      S_CB_CLR: begin
        vld  = 1'b1;
        code = CODE_CBCLR;
        if (cmd.cmd_ready)
          state_n = (abort_pend || n_pulses_q == '0) ? S_OFF : S_NEG;
      end
`endif
      S_NEG: begin
        vld  = 1'b1;
        data = {1'b0, ele_q, x50_q, 1'b0, 2'b01, amp_neg_q};
        if (cmd.cmd_ready) state_n = abort_pend ? S_OFF : S_NEG_WAIT;
      end
      S_NEG_WAIT: begin
        if (abort_pend)      state_n = S_OFF;
        else if (timer_last) state_n = S_ZERO;
      end
      S_ZERO: begin
        vld  = 1'b1;
        data = {1'b0, ele_q, x50_q, 1'b0, 2'b00, amp_neg_q};
        if (cmd.cmd_ready) state_n = abort_pend ? S_OFF : S_IPG_WAIT;
      end
      S_IPG_WAIT: begin
        if (abort_pend)      state_n = S_OFF;
        else if (timer_last) state_n = S_POS;
      end
      S_POS: begin
        vld  = 1'b1;
        data = {1'b0, ele_q, x50_q, 1'b0, 2'b10, amp_pos_q};
        if (cmd.cmd_ready) state_n = abort_pend ? S_OFF : S_POS_WAIT;
      end
      S_POS_WAIT: begin
        if (abort_pend)      state_n = S_OFF;
        else if (timer_last) state_n = more_pulses ? S_NEG : S_OFF;
      end
      S_OFF: begin
        vld  = 1'b1;
        data = {1'b1, ele_q, x50_q, 1'b0, 2'b00, 9'd0};
        if (cmd.cmd_ready) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      amp_neg_q  <= '0;
      amp_pos_q  <= '0;
      x50_q      <= 1'b0;
      ele_q      <= '0;
      t_phase_q  <= '0;
      t_ipg_q    <= '0;
      n_pulses_q <= '0;
      abort_q    <= 1'b0;
      timer      <= '0;
      pulse_cnt  <= '0;
    end else begin
      if (timer != '0) timer <= timer - 16'd1;
      if (state == S_IDLE && start) begin
        addr_q     <= cfg_addr;
        amp_neg_q  <= cfg_amp_neg;
        amp_pos_q  <= cfg_amp_pos;
        x50_q      <= cfg_x50;
        ele_q      <= cfg_ele;
        t_phase_q  <= cfg_t_phase;
        t_ipg_q    <= cfg_t_ipg;
        n_pulses_q <= cfg_n_pulses;
        abort_q    <= 1'b0;
        pulse_cnt  <= '0;
      end else if (state == S_DONE) begin
        abort_q <= 1'b0;
      end else if (state != S_IDLE && abort) begin
        abort_q <= 1'b1;
      end
      // Timers load on the handshake cycle so the wait spans exactly max(t,1) cycles.
      if (xfer) begin
        case (state)
          S_NEG, S_POS: timer <= max1(t_phase_q);
          S_ZERO:       timer <= max1(t_ipg_q);
`ifdef STIM_SEQ_COMP_EN
          S_COMP_OFF:   timer <= (CB_TIMEOUT == 0) ? 16'd1 : 16'(CB_TIMEOUT);
`endif
          default: ;
        endcase
      end
      if (pulse_inc && pulse_cnt != 8'hFF) pulse_cnt <= pulse_cnt + 8'd1;
    end
  end

`ifdef STIM_SEQ_COMP_EN
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)                         err_timeout <= 1'b0;
    else if (state == S_IDLE && start)  err_timeout <= 1'b0;
    else if (state == S_POLL_CB && !abort_pend && !cb_ok && timer_last)
                                        err_timeout <= 1'b1;
  end
`else
  logic unused_cb;
  assign unused_cb   = cb_ok | (CB_TIMEOUT == 0);
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stim_seq_ctrl.sv
// Self-checking bench for stim_seq_ctrl: a scoreboard of expected command words
// plus per-scenario checks of timing, status outputs, abort and reset behaviour.
module tb_stim_seq_ctrl;
  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, abort = 1'b0, cb_ok = 1'b1;
  logic [9:0]  cfg_addr = '0;
  logic [8:0]  cfg_amp_neg = '0, cfg_amp_pos = '0;
  logic        cfg_x50 = 1'b0;
  logic [1:0]  cfg_ele = '0;
  logic [15:0] cfg_t_phase = '0, cfg_t_ipg = '0;
  logic [7:0]  cfg_n_pulses = '0;
  logic        busy, done, err_timeout;
  logic [7:0]  pulse_cnt;

`ifdef STIM_SEQ_COMP_EN
  localparam int PRE = 3;
`else
  localparam int PRE = 0;
`endif

  stim_seq_ctrl_if cmd_if();

  stim_seq_ctrl #(.CB_TIMEOUT(50)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_amp_neg(cfg_amp_neg), .cfg_amp_pos(cfg_amp_pos),
    .cfg_x50(cfg_x50), .cfg_ele(cfg_ele), .cfg_t_phase(cfg_t_phase),
    .cfg_t_ipg(cfg_t_ipg), .cfg_n_pulses(cfg_n_pulses), .cmd(cmd_if),
    .cb_ok(cb_ok), .busy(busy), .done(done), .err_timeout(err_timeout),
    .pulse_cnt(pulse_cnt)
  );

  always #5 clk_50M = ~clk_50M;

  int          n_checks = 0, n_fail = 0, cyc = 0, done_cnt = 0, d_base = 0;
  logic [31:0] exp_q[$];
  int          xt[$];
  logic [31:0] exp_w;

  always @(posedge clk_50M) cyc++;

  // Scoreboard: every transferred word is popped against the expected stream.
  always @(negedge clk_50M) begin
    if (done) done_cnt++;
    if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      xt.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected got %h required none", cmd_if.cmd_word);
      end else begin
        exp_w = exp_q.pop_front();
        if (cmd_if.cmd_word !== exp_w) begin
          n_fail++;
          $display("FAIL cmd_word got %h required %h", cmd_if.cmd_word, exp_w);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic off, input logic comp,
                                     input logic [1:0] pol, input logic [8:0] amp);
    return {6'd6, cfg_addr, off, cfg_ele, cfg_x50, comp, pol, amp};
  endfunction

  function automatic void push_train(input int n, input bit pre);
    if (pre) begin
`ifdef STIM_SEQ_COMP_EN
      exp_q.push_back(mk(1'b0, 1'b1, 2'b00, cfg_amp_neg));
      exp_q.push_back(mk(1'b0, 1'b0, 2'b00, cfg_amp_neg));
      exp_q.push_back({6'd18, cfg_addr, 16'h0000});
`endif
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 2'b01, cfg_amp_neg));
      exp_q.push_back(mk(1'b0, 1'b0, 2'b00, cfg_amp_neg));
      exp_q.push_back(mk(1'b0, 1'b0, 2'b10, cfg_amp_pos));
    end
    exp_q.push_back(mk(1'b1, 1'b0, 2'b00, 9'd0));
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic set_cfg(input logic [9:0] a, input logic [7:0] n,
                         input logic [15:0] tp, input logic [15:0] ti);
    cfg_addr = a; cfg_n_pulses = n; cfg_t_phase = tp; cfg_t_ipg = ti;
    cfg_amp_neg = a[8:0] ^ 9'h0A5; cfg_amp_pos = a[8:0] ^ 9'h15A;
    cfg_ele = a[1:0]; cfg_x50 = a[2];
  endtask

  task automatic kick(input logic ab);
    xt.delete();
    d_base = done_cnt;
    start = 1'b1; abort = ab;
    step(1);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    for (int i = 0; i < limit && done_cnt == d_base; i++) step(1);
    n_checks++;
    if (done_cnt == d_base) begin
      n_fail++;
      $display("FAIL %s_done_timeout got no done within %0d cycles required done", nm, limit);
    end
    step(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_checks++;
    if ({cmd_if.cmd_valid, busy, done, err_timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b required 0000", {cmd_if.cmd_valid, busy, done, err_timeout});
    end
    n_checks++;
    if (cmd_if.cmd_word !== 32'h0 || pulse_cnt !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data got word %h cnt %0d required 0 0", cmd_if.cmd_word, pulse_cnt);
    end
    rst_n = 1'b1;
    step(2);
    n_checks++;
    if ({cmd_if.cmd_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b required 00", {cmd_if.cmd_valid, busy});
    end
  endtask

  task automatic test_basic();
    set_cfg(10'h2A5, 8'd2, 16'd100, 16'd25);
    push_train(2, 1'b1);
    kick(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy got %b required 1", busy);
    end
    wait_done("basic", 1000);
    n_checks++;
    if (xt.size() != PRE + 7) begin
      n_fail++;
      $display("FAIL basic_word_count got %0d required %0d", xt.size(), PRE + 7);
    end
    n_checks++;
    if (xt[PRE+1] - xt[PRE] != 101) begin
      n_fail++;
      $display("FAIL neg_to_zero_spacing got %0d required 101", xt[PRE+1] - xt[PRE]);
    end
    n_checks++;
    if (xt[PRE+2] - xt[PRE+1] != 26) begin
      n_fail++;
      $display("FAIL zero_to_pos_spacing got %0d required 26", xt[PRE+2] - xt[PRE+1]);
    end
    n_checks++;
    if (pulse_cnt !== 8'd2 || done_cnt != d_base + 1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status got cnt %0d dones %0d busy %b err %b required 2 1 0 0",
               pulse_cnt, done_cnt - d_base, busy, err_timeout);
    end
  endtask

  task automatic test_t_zero();
    set_cfg(10'h13C, 8'd1, 16'd0, 16'd1);
    push_train(1, 1'b1);
    kick(1'b0);
    wait_done("t_zero", 200);
    n_checks++;
    if (xt[PRE+1] - xt[PRE] != 2 || xt[PRE+2] - xt[PRE+1] != 2) begin
      n_fail++;
      $display("FAIL min_wait_spacing got %0d,%0d required 2,2",
               xt[PRE+1] - xt[PRE], xt[PRE+2] - xt[PRE+1]);
    end
    n_checks++;
    if (exp_q.size() != 0 || pulse_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL t_zero_status got left %0d cnt %0d required 0 1", exp_q.size(), pulse_cnt);
    end
  endtask

  task automatic test_backpressure();
    set_cfg(10'h0F6, 8'd1, 16'd3, 16'd2);
    cmd_if.cmd_ready = 1'b0;
    push_train(1, 1'b1);
    kick(1'b0);
    for (int i = 0; i < 20 && !cmd_if.cmd_valid; i++) step(1);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_word !== exp_q[0]) begin
        n_fail++;
        $display("FAIL hold_word cycle %0d got %b/%h required 1/%h", i,
                 cmd_if.cmd_valid, cmd_if.cmd_word, exp_q[0]);
      end
      step(1);
    end
    n_checks++;
    if (xt.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_no_advance got xfers %0d busy %b required 0 1", xt.size(), busy);
    end
    cmd_if.cmd_ready = 1'b1;
    wait_done("backpressure", 200);
    n_checks++;
    if (exp_q.size() != 0 || pulse_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL backpressure_status got left %0d cnt %0d required 0 1", exp_q.size(), pulse_cnt);
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(10'h351, 8'd3, 16'd4, 16'd2);
    push_train(3, 1'b1);
    kick(1'b0);
    n_checks++;
    if (pulse_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL cnt_clear_on_start got %0d required 0", pulse_cnt);
    end
    step(5);
    set_cfg(10'h0AA, 8'd7, 16'd9, 16'd9);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("back_to_back", 400);
    n_checks++;
    if (exp_q.size() != 0 || pulse_cnt !== 8'd3 || done_cnt != d_base + 1) begin
      n_fail++;
      $display("FAIL start_ignored_busy got left %0d cnt %0d dones %0d required 0 3 1",
               exp_q.size(), pulse_cnt, done_cnt - d_base);
    end
  endtask

  task automatic test_abort();
    set_cfg(10'h1C7, 8'd3, 16'd50, 16'd5);
    push_train(0, 1'b1);
    exp_q.insert(PRE, mk(1'b0, 1'b0, 2'b01, cfg_amp_neg));
    kick(1'b0);
    for (int i = 0; i < 100 && xt.size() < PRE + 1; i++) step(1);
    step(10);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_done("abort", 50);
    n_checks++;
    if (exp_q.size() != 0 || pulse_cnt !== 8'd0 || done_cnt != d_base + 1) begin
      n_fail++;
      $display("FAIL abort_status got left %0d cnt %0d dones %0d required 0 0 1",
               exp_q.size(), pulse_cnt, done_cnt - d_base);
    end
  endtask

  task automatic test_start_abort();
    set_cfg(10'h2EE, 8'd4, 16'd6, 16'd3);
    push_train(0, 1'b0);
    kick(1'b1);
    wait_done("start_abort", 50);
    n_checks++;
    if (exp_q.size() != 0 || xt.size() != 1 || pulse_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL start_abort_status got left %0d words %0d cnt %0d required 0 1 0",
               exp_q.size(), xt.size(), pulse_cnt);
    end
  endtask

  task automatic test_zero_pulses();
    set_cfg(10'h08B, 8'd0, 16'd6, 16'd3);
    push_train(0, 1'b1);
    kick(1'b0);
    wait_done("zero_pulses", 100);
    n_checks++;
    if (exp_q.size() != 0 || xt.size() != PRE + 1 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulses_status got left %0d words %0d err %b required 0 %0d 0",
               exp_q.size(), xt.size(), err_timeout, PRE + 1);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(10'h3F2, 8'd2, 16'd20, 16'd4);
    push_train(2, 1'b1);
    kick(1'b0);
    for (int i = 0; i < 200 && xt.size() < PRE + 3; i++) step(1);
    step(5);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_if.cmd_valid, busy, done, err_timeout} !== 4'b0000 || cmd_if.cmd_word !== 32'h0
        || pulse_cnt !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got %b word %h cnt %0d required 0000 0 0",
               {cmd_if.cmd_valid, busy, done, err_timeout}, cmd_if.cmd_word, pulse_cnt);
    end
    exp_q.delete();
    step(3);
    n_checks++;
    if (xt.size() != PRE + 3) begin
      n_fail++;
      $display("FAIL reset_mid_no_off got words %0d required %0d", xt.size(), PRE + 3);
    end
    rst_n = 1'b1;
    step(2);
    set_cfg(10'h155, 8'd1, 16'd3, 16'd3);
    push_train(1, 1'b1);
    kick(1'b0);
    wait_done("after_reset", 200);
    n_checks++;
    if (exp_q.size() != 0 || pulse_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL after_reset_status got left %0d cnt %0d required 0 1", exp_q.size(), pulse_cnt);
    end
  endtask

`ifdef STIM_SEQ_COMP_EN
  task automatic test_cb_timeout();
    set_cfg(10'h234, 8'd2, 16'd5, 16'd5);
    cb_ok = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 2'b00, cfg_amp_neg));
    exp_q.push_back(mk(1'b0, 1'b0, 2'b00, cfg_amp_neg));
    exp_q.push_back(mk(1'b1, 1'b0, 2'b00, 9'd0));
    kick(1'b0);
    wait_done("cb_timeout", 200);
    n_checks++;
    if (err_timeout !== 1'b1 || exp_q.size() != 0 || xt[2] - xt[1] != 51) begin
      n_fail++;
      $display("FAIL cb_timeout got err %b left %0d spacing %0d required 1 0 51",
               err_timeout, exp_q.size(), xt[2] - xt[1]);
    end
    cb_ok = 1'b1;
  endtask

  task automatic test_comp_cb();
    set_cfg(10'h1E9, 8'd2, 16'd10, 16'd5);
    cb_ok = 1'b0;
    push_train(2, 1'b1);
    kick(1'b0);
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_start got %b required 0", err_timeout);
    end
    for (int i = 0; i < 50 && xt.size() < 2; i++) step(1);
    step(40);
    cb_ok = 1'b1;
    wait_done("comp_cb", 400);
    n_checks++;
    if (xt[2] - xt[1] != 42 || exp_q.size() != 0 || pulse_cnt !== 8'd2 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL comp_cb got spacing %0d left %0d cnt %0d err %b required 42 0 2 0",
               xt[2] - xt[1], exp_q.size(), pulse_cnt, err_timeout);
    end
  endtask
`endif

  initial begin
    cmd_if.cmd_ready = 1'b1;
    test_reset();
    test_basic();
    test_t_zero();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_start_abort();
    test_zero_pulses();
    test_reset_mid();
`ifdef STIM_SEQ_COMP_EN
    test_cb_timeout();
    test_comp_cb();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish required finish within 2ms");
    $fatal(1, "simulation watchdog expired");
  end
endmodule
